// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state enum for the systolic feeder and array
package systolic_pkg;

  localparam int ARR_N     = 4;
  localparam int FEED_LEN  = 2 * ARR_N - 1;
  localparam int DRAIN_LEN = ARR_N - 1;
  localparam int LANE_W    = $clog2(ARR_N);
  localparam int STEP_W    = $clog2(FEED_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - operand load, control and skewed stream bundle of the feeder
interface systolic_feeder_if #(
  parameter int DATA_W = 32
);

  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              arr_clr;
  logic              feed_done;
  logic [DATA_W-1:0] out_west0;
  logic [DATA_W-1:0] out_west1;
  logic [DATA_W-1:0] out_west2;
  logic [DATA_W-1:0] out_west3;
  logic [DATA_W-1:0] out_north0;
  logic [DATA_W-1:0] out_north1;
  logic [DATA_W-1:0] out_north2;
  logic [DATA_W-1:0] out_north3;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, arr_clr, feed_done,
    input  out_west0, out_west1, out_west2, out_west3,
    input  out_north0, out_north1, out_north2, out_north3
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, arr_clr, feed_done,
    output out_west0, out_west1, out_west2, out_west3,
    output out_north0, out_north1, out_north2, out_north3
  );

endinterface

// File: rtl/systolic_feeder_lane.sv
// rtl/systolic_feeder_lane.sv - picks the diagonally skewed word of one lane for a feed step
module feed_lane
  import systolic_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [STEP_W-1:0] step,
  input  logic [DATA_W-1:0] words [ARR_N],
  output logic [DATA_W-1:0] word
);

  localparam int DIFF_W = STEP_W + 1;

  logic [DIFF_W-1:0] diff;

  // Lane i sees element t-i; a negative or past-the-end offset yields a zero bubble
  always_comb begin
    diff = {1'b0, step} - DIFF_W'(lane);
    word = '0;
    if (!diff[DIFF_W-1] && diff < DIFF_W'(ARR_N)) begin
      word = words[diff[LANE_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand storage, feed sequencer and registered skewed streams
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic              busy_q;
  logic              clr_q;
  logic              done_q;

  logic [DATA_W-1:0] mem_a [ARR_N*ARR_N];
  logic [DATA_W-1:0] mem_b [ARR_N*ARR_N];

  logic [DATA_W-1:0] west_words  [ARR_N][ARR_N];
  logic [DATA_W-1:0] north_words [ARR_N][ARR_N];
  logic [DATA_W-1:0] west_lane   [ARR_N];
  logic [DATA_W-1:0] north_lane  [ARR_N];
  logic [DATA_W-1:0] west_q      [ARR_N];
  logic [DATA_W-1:0] north_q     [ARR_N];

  logic [STEP_W-1:0] lane_step;
  logic              lane_load;

  // Lanes look one step ahead so the registered outputs carry step t during FEED step t
  always_comb begin
    lane_step = (state_q == FEED) ? step_q + STEP_W'(1) : '0;
    lane_load = (state_q == CLEAR) ||
                ((state_q == FEED) && (step_q != STEP_W'(FEED_LEN - 1)));
  end

  // Operand storage; writes only land while idle so a running feed sees stable operands
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ARR_N * ARR_N; k++) begin
        mem_a[k] <= '0;
        mem_b[k] <= '0;
      end
    end else if (state_q == IDLE && bus.wr_en) begin
      if (bus.wr_sel) mem_b[bus.wr_addr] <= bus.wr_data;
      else            mem_a[bus.wr_addr] <= bus.wr_data;
    end
  end

  // West lanes take rows of A, north lanes take columns of B
  always_comb begin
    for (int i = 0; i < ARR_N; i++) begin
      for (int k = 0; k < ARR_N; k++) begin
        west_words[i][k]  = mem_a[i*ARR_N + k];
        north_words[i][k] = mem_b[k*ARR_N + i];
      end
    end
  end

  for (genvar g = 0; g < ARR_N; g++) begin : g_lane
    feed_lane #(.DATA_W(DATA_W)) u_west (
      .lane  (LANE_W'(g)),
      .step  (lane_step),
      .words (west_words[g]),
      .word  (west_lane[g])
    );
    feed_lane #(.DATA_W(DATA_W)) u_north (
      .lane  (LANE_W'(g)),
      .step  (lane_step),
      .words (north_words[g]),
      .word  (north_lane[g])
    );
  end

  // Register the stream words; anything outside the feed window is forced to zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < ARR_N; i++) begin
      if (rst || !lane_load) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end else begin
        west_q[i]  <= west_lane[i];
        north_q[i] <= north_lane[i];
      end
    end
  end

  // Sequencer: IDLE -> CLEAR -> FEED x7 -> DRAIN x3 -> DONE -> IDLE with registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          step_q <= '0;
          if (bus.start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= FEED;
          step_q  <= '0;
          clr_q   <= 1'b0;
        end
        FEED: begin
          if (step_q == STEP_W'(FEED_LEN - 1)) begin
            state_q <= DRAIN;
            step_q  <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        DRAIN: begin
          if (step_q == STEP_W'(DRAIN_LEN - 1)) begin
            state_q <= DONE;
            step_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          step_q  <= '0;
          busy_q  <= 1'b0;
          clr_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.arr_clr    = clr_q;
  assign bus.feed_done  = done_q;
  assign bus.out_west0  = west_q[0];
  assign bus.out_west1  = west_q[1];
  assign bus.out_west2  = west_q[2];
  assign bus.out_west3  = west_q[3];
  assign bus.out_north0 = north_q[0];
  assign bus.out_north1 = north_q[1];
  assign bus.out_north2 = north_q[2];
  assign bus.out_north3 = north_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_W(DW)) bus ();

  systolic_feeder #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ea [16];
  logic [DW-1:0] eb [16];

  logic [DW-1:0] sw [15][4];
  logic [DW-1:0] sn [15][4];
  logic          sclr  [15];
  logic          sdone [15];
  logic          sbusy [15];

  logic [DW-1:0] west_vec  [4];
  logic [DW-1:0] north_vec [4];
  assign west_vec[0]  = bus.out_west0;
  assign west_vec[1]  = bus.out_west1;
  assign west_vec[2]  = bus.out_west2;
  assign west_vec[3]  = bus.out_west3;
  assign north_vec[0] = bus.out_north0;
  assign north_vec[1] = bus.out_north1;
  assign north_vec[2] = bus.out_north2;
  assign north_vec[3] = bus.out_north3;

  logic [DW-1:0] pa [4][4];
  logic [DW-1:0] pb [4][4];
  logic [63:0]   acc      [4][4];
  logic [63:0]   acc_snap [4][4];

  // Output-stationary 4x4 array: operands march east/south, each cell accumulates
  always @(posedge clk) begin : array_model
    logic [DW-1:0] w;
    logic [DW-1:0] n;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) w = west_vec[i];
        else        w = pa[i][j-1];
        if (i == 0) n = north_vec[j];
        else        n = pb[i-1][j];
        pa[i][j] <= w;
        pb[i][j] <= n;
        if (bus.arr_clr) acc[i][j] <= 64'd0;
        else             acc[i][j] <= acc[i][j] + 64'(w) * 64'(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_w(int i, int t);
    if (t >= i && t - i <= 3) return ea[i*4 + t - i];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_n(int j, int t);
    if (t >= j && t - j <= 3) return eb[(t-j)*4 + j];
    return '0;
  endfunction

  function automatic logic [DW-1:0] snap_or(int c);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r = r | sw[c][k] | sn[c][k];
    return r;
  endfunction

  function automatic int done_count();
    int s;
    s = 0;
    for (int c = 1; c < 15; c++) if (sdone[c] === 1'b1) s++;
    return s;
  endfunction

  task automatic load(input logic sel, input int addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    if (sel) eb[addr] = data;
    else     ea[addr] = data;
  endtask

  task automatic clear_shadow();
    for (int k = 0; k < 16; k++) begin
      ea[k] = '0;
      eb[k] = '0;
    end
  endtask

  // start sampled at edge E; cycle c is the cycle after edge E+c-1. Optional injections
  // of an A[0][0] write, a start pulse or a reset are driven during the given cycle.
  task automatic run_seq(input int wr_c, input logic [DW-1:0] wr_v, input int st_c, input int rst_c);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) acc_snap[i][j] = '1;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = wr_v;
    bus.wr_en   = (wr_c == 0);
    bus.start   = 1'b1;
    for (int c = 1; c < 15; c++) begin
      tick();
      sclr[c]  = bus.arr_clr;
      sdone[c] = bus.feed_done;
      sbusy[c] = bus.busy;
      for (int k = 0; k < 4; k++) begin
        sw[c][k] = west_vec[k];
        sn[c][k] = north_vec[k];
      end
      if (bus.feed_done === 1'b1) acc_snap = acc;
      bus.start = (c == st_c);
      bus.wr_en = (c == wr_c);
      rst       = (c == rst_c);
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ((bus.out_west0 | bus.out_west1 | bus.out_west2 | bus.out_west3 |
         bus.out_north0 | bus.out_north1 | bus.out_north2 | bus.out_north3) !== '0) begin
      n_fail++; $display("FAIL reset_data: got nonzero stream, expected 0");
    end
    n_tests++;
    if ({bus.busy, bus.arr_clr, bus.feed_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.arr_clr, bus.feed_done});
    end
    rst = 1'b0;
    tick();
    clear_shadow();
    run_seq(-1, '0, -1, -1);
    n_tests++;
    if (sclr[1] !== 1'b1 || sbusy[1] !== 1'b1) begin
      n_fail++; $display("FAIL zero_clr_e1: got clr=%b busy=%b expected 1 1", sclr[1], sbusy[1]);
    end
    n_tests++;
    if (sclr[2] !== 1'b0) begin
      n_fail++; $display("FAIL zero_clr_e2: got %b expected 0", sclr[2]);
    end
    for (int c = 1; c < 14; c++) begin
      n_tests++;
      if (snap_or(c) !== '0) begin
        n_fail++; $display("FAIL zero_data c=%0d: got %h expected 0", c, snap_or(c));
      end
    end
    n_tests++;
    if (sdone[12] !== 1'b1 || sbusy[12] !== 1'b1) begin
      n_fail++; $display("FAIL zero_done_e12: got done=%b busy=%b expected 1 1", sdone[12], sbusy[12]);
    end
    n_tests++;
    if (done_count() != 1) begin
      n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_count());
    end
    n_tests++;
    if (sbusy[13] !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy_e13: got %b expected 0", sbusy[13]);
    end
  endtask

  task automatic test_skew();
    for (int k = 0; k < 16; k++) load(1'b0, k, DW'(k + 1));
    for (int k = 0; k < 16; k++) load(1'b1, k, DW'(100 + k));
    run_seq(-1, '0, -1, -1);
    n_tests++;
    if (sw[2][0] !== 32'd1 || sn[2][0] !== 32'd100) begin
      n_fail++; $display("FAIL skew_t0: got west0=%0d north0=%0d expected 1 100", sw[2][0], sn[2][0]);
    end
    n_tests++;
    if ((sw[2][1] | sw[2][2] | sw[2][3] | sn[2][1] | sn[2][2] | sn[2][3]) !== '0) begin
      n_fail++; $display("FAIL skew_t0_others: got nonzero expected 0");
    end
    n_tests++;
    if (sn[4][2] !== 32'd102 || sn[4][0] !== 32'd108) begin
      n_fail++; $display("FAIL skew_t2: got north2=%0d north0=%0d expected 102 108", sn[4][2], sn[4][0]);
    end
    n_tests++;
    if (sw[5][0] !== 32'd4 || sw[5][3] !== 32'd13) begin
      n_fail++; $display("FAIL skew_t3: got west0=%0d west3=%0d expected 4 13", sw[5][0], sw[5][3]);
    end
    n_tests++;
    if (sw[8][3] !== 32'd16 || sn[8][3] !== 32'd115 ||
        (sw[8][0] | sw[8][1] | sw[8][2] | sn[8][0] | sn[8][1] | sn[8][2]) !== '0) begin
      n_fail++; $display("FAIL skew_t6: got west3=%0d north3=%0d expected 16 115 others 0", sw[8][3], sn[8][3]);
    end
    for (int c = 1; c < 14; c++) begin
      for (int k = 0; k < 4; k++) begin
        logic [DW-1:0] xw, xn;
        xw = (c >= 2 && c <= 8) ? exp_w(k, c - 2) : '0;
        xn = (c >= 2 && c <= 8) ? exp_n(k, c - 2) : '0;
        n_tests++;
        if (sw[c][k] !== xw || sn[c][k] !== xn) begin
          n_fail++; $display("FAIL skew_model c=%0d lane=%0d: got %0d/%0d expected %0d/%0d", c, k, sw[c][k], sn[c][k], xw, xn);
        end
      end
    end
    n_tests++;
    if (sdone[12] !== 1'b1) begin
      n_fail++; $display("FAIL skew_done: got %b expected 1", sdone[12]);
    end
  endtask

  task automatic test_blocked();
    run_seq(4, 32'd7, 5, -1);
    n_tests++;
    if (done_count() != 1) begin
      n_fail++; $display("FAIL blocked_done_count: got %0d expected 1", done_count());
    end
    n_tests++;
    if (sbusy[13] !== 1'b0 || sbusy[14] !== 1'b0) begin
      n_fail++; $display("FAIL blocked_restart: got busy13=%b busy14=%b expected 0 0", sbusy[13], sbusy[14]);
    end
    run_seq(-1, '0, -1, -1);
    n_tests++;
    if (sw[2][0] !== 32'd1) begin
      n_fail++; $display("FAIL blocked_write: got A00=%0d expected 1", sw[2][0]);
    end
  endtask

  task automatic test_same_cycle();
    run_seq(0, 32'd55, -1, -1);
    ea[0] = 32'd55;
    n_tests++;
    if (sw[2][0] !== 32'd55) begin
      n_fail++; $display("FAIL same_cycle_west0: got %0d expected 55", sw[2][0]);
    end
    n_tests++;
    if (sw[3][1] !== 32'd5) begin
      n_fail++; $display("FAIL same_cycle_west1: got %0d expected 5", sw[3][1]);
    end
  endtask

  task automatic test_reset_mid();
    run_seq(-1, '0, -1, 6);
    clear_shadow();
    n_tests++;
    if (sbusy[7] !== 1'b0 || sclr[7] !== 1'b0 || sdone[7] !== 1'b0 || snap_or(7) !== '0) begin
      n_fail++; $display("FAIL midrst_idle: got busy=%b clr=%b done=%b data=%h expected all 0", sbusy[7], sclr[7], sdone[7], snap_or(7));
    end
    n_tests++;
    if (done_count() != 0) begin
      n_fail++; $display("FAIL midrst_done_count: got %0d expected 0", done_count());
    end
    run_seq(-1, '0, -1, -1);
    n_tests++;
    if (sw[2][0] !== 32'd0 || sn[2][0] !== 32'd0) begin
      n_fail++; $display("FAIL midrst_storage: got west0=%0d north0=%0d expected 0 0", sw[2][0], sn[2][0]);
    end
    n_tests++;
    if (sdone[12] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_rerun_done: got %b expected 1", sdone[12]);
    end
  endtask

  task automatic test_end_to_end();
    for (int k = 0; k < 16; k++) load(1'b0, k, (k / 4 == k % 4) ? 32'd1 : 32'd0);
    for (int k = 0; k < 16; k++) load(1'b1, k, DW'($urandom));
    run_seq(-1, '0, -1, -1);
    n_tests++;
    if (sdone[12] !== 1'b1) begin
      n_fail++; $display("FAIL e2e_done: got %b expected 1", sdone[12]);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        n_tests++;
        if (acc_snap[i][j] !== {32'd0, eb[i*4 + j]}) begin
          n_fail++; $display("FAIL e2e_c%0d%0d: got %h expected %h", i, j, acc_snap[i][j], {32'd0, eb[i*4 + j]});
        end
      end
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    test_reset();
    test_skew();
    test_blocked();
    test_same_cycle();
    test_reset_mid();
    test_end_to_end();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
